keymill_fifo_reader: RTL and testbench

Burst reader for the keymill coprocessor's 32-bit show-ahead word FIFO. On a start command it pops a programmed number of words from the FIFO. It presents them to the downstream consumer on a registered valid/ready interface at up to one word per cycle. It reports completion, plus an error if the FIFO stays empty too long. It sits between the FIFO's read port and the coprocessor's output bus.

---
 rtl/keymill_pkg.sv | 14 +
 rtl/keymill_fifo_reader.sv | 137 +++++++++++++
 tb/tb_keymill_fifo_reader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/keymill_pkg.sv
// Shared keymill coprocessor types and constants.
// The FIFO and the burst reader both take their word width from here.
package keymill_pkg;

  localparam int KM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } km_state_t;

endpackage : keymill_pkg

// File: rtl/keymill_fifo_reader.sv
// Burst reader: pops burst_len words from a show-ahead FIFO into a registered
// valid/ready output stage, with starvation timeout and completion reporting.
module keymill_fifo_reader
  import keymill_pkg::*;
#(
  parameter int DATA_W  = KM_DATA_W,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_sent
);

  localparam int STARVE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  km_state_t            state, state_nxt;
  logic [LEN_W-1:0]     rem;
  logic [STARVE_W-1:0]  starve_cnt;
  logic [STARVE_W-1:0]  starve_inc;

  logic start_go;
  logic pop;
  logic accept;
  logic starved;
  logic timeout_hit;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    start_go    = 1'b0;
    pop         = 1'b0;
    accept      = 1'b0;
    starved     = 1'b0;
    timeout_hit = 1'b0;
    starve_inc  = starve_cnt + 1'b1;
    state_nxt   = state;

    start_go = (state == IDLE) && start;
    accept   = out_valid && out_ready;
    pop      = (state == RUN) && (rem != '0) && !fifo_empty &&
               (!out_valid || out_ready);
    starved  = (state == RUN) && (rem != '0) && fifo_empty;
    if (TIMEOUT != 0)
      timeout_hit = starved && (starve_inc == STARVE_W'(TIMEOUT));

    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = (burst_len != '0) ? RUN : DONE;
      end
      RUN: begin
        // The final pop and a timeout both hand over to DRAIN so the word
        // still sitting in the output register is delivered.
        if (timeout_hit || (pop && rem == LEN_W'(1)))
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!out_valid || out_ready)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign fifo_rd_en = pop;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
      done  <= (state_nxt == DONE);
    end
  end

  // Output register: a pop always wins over an accept so back-to-back words
  // keep out_valid high with the new word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (pop) begin
      out_data  <= fifo_data;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem        <= '0;
      starve_cnt <= '0;
      err        <= 1'b0;
      words_sent <= '0;
    end else begin
      if (start_go && burst_len != '0)
        rem <= burst_len;
      else if (pop)
        rem <= rem - 1'b1;

      if (start_go || pop)
        starve_cnt <= '0;
      else if (starved)
        starve_cnt <= starve_inc;

      if (start_go)
        err <= 1'b0;
      else if (timeout_hit)
        err <= 1'b1;

      if (start_go)
        words_sent <= '0;
      else if (accept && words_sent != '1)
        words_sent <= words_sent + 1'b1;
    end
  end

endmodule : keymill_fifo_reader

// File: tb/tb_keymill_fifo_reader.sv
// Directed bench for keymill_fifo_reader with a behavioural show-ahead FIFO
// and a handshake monitor; inputs change and outputs are sampled on negedge.
module tb_keymill_fifo_reader;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic              err;
  logic [LEN_W-1:0]  words_sent;

  keymill_fifo_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model; rd_ptr doubles as the running pop count.
  logic [DATA_W-1:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr % 16];

  // Monitor: edge count, accepted words, done pulses, stall stability.
  logic [DATA_W-1:0] rx [0:63];
  int          rx_cnt      = 0;
  int          cyc         = 0;
  int          pop_edge    = 0;
  int          done_cnt    = 0;
  int          stall_cnt   = 0;
  int          stab_err    = 0;
  int          empty_pops  = 0;
  logic        prev_stall  = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      if (rd_ptr == wr_ptr) empty_pops <= empty_pops + 1;
      rd_ptr   <= rd_ptr + 1;
      pop_edge <= cyc + 1;
    end
    if (out_valid && out_ready && rx_cnt < 64) begin
      rx[rx_cnt] <= out_data;
      rx_cnt     <= rx_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (prev_stall && out_valid && out_data !== prev_data) stab_err <= stab_err + 1;
    if (out_valid && !out_ready) stall_cnt <= stall_cnt + 1;
    prev_stall <= out_valid && !out_ready;
    prev_data  <= out_data;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [DATA_W-1:0] w);
    mem[wr_ptr % 16] = w;
    wr_ptr++;
  endtask

  // Leaves the bench at the negedge following the edge that sampled start.
  task automatic do_start(input logic [LEN_W-1:0] len);
    start     = 1'b1;
    burst_len = len;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    bit found = 1'b0;
    for (int i = 0; i < max_cycles && !found; i++) begin
      tick();
      if (done) found = 1'b1;
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  int base_rx, base_pop, base_done, err_edge;
  bit got;

  initial begin
    rst = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data",  out_data, 32'd0);
    chk("rst_busy_done_err_rd", {28'd0, busy, done, err, fifo_rd_en}, 32'd0);
    chk("rst_words_sent", {24'd0, words_sent}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Burst of 4, consumer always ready: one word per cycle, 2-cycle latency.
    push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333); push(32'h4444_4444);
    base_done = done_cnt;
    do_start(8'd4);
    chk("b4_busy_k", {31'd0, busy}, 32'd1);
    chk("b4_valid_k", {31'd0, out_valid}, 32'd0);
    tick(); chk("b4_w0", out_valid ? out_data : 32'hDEAD_BEEF, 32'h1111_1111);
    tick(); chk("b4_w1", out_valid ? out_data : 32'hDEAD_BEEF, 32'h2222_2222);
    tick(); chk("b4_w2", out_valid ? out_data : 32'hDEAD_BEEF, 32'h3333_3333);
    tick(); chk("b4_w3", out_valid ? out_data : 32'hDEAD_BEEF, 32'h4444_4444);
    tick();
    chk("b4_done_pulse", {30'd0, done, out_valid}, 32'd2);
    tick();
    chk("b4_done_once", done_cnt - base_done, 32'd1);
    chk("b4_idle", {30'd0, busy, done}, 32'd0);
    chk("b4_words_sent", {24'd0, words_sent}, 32'd4);
    chk("b4_err", {31'd0, err}, 32'd0);
    chk("b4_fifo_empty", wr_ptr - rd_ptr, 32'd0);

    // Same burst with out_ready pattern 1,0,0,1: stalls must hold the word.
    push(32'h1111_1111); push(32'h2222_2222); push(32'h3333_3333); push(32'h4444_4444);
    base_rx = rx_cnt; base_pop = rd_ptr;
    do_start(8'd4);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      tick();
      if (done) got = 1'b1;
    end
    out_ready = 1'b1;
    chk("stall_done_seen", {31'd0, got}, 32'd1);
    chk("stall_rx_count", rx_cnt - base_rx, 32'd4);
    chk("stall_rx0", rx[base_rx],     32'h1111_1111);
    chk("stall_rx1", rx[base_rx + 1], 32'h2222_2222);
    chk("stall_rx2", rx[base_rx + 2], 32'h3333_3333);
    chk("stall_rx3", rx[base_rx + 3], 32'h4444_4444);
    chk("stall_pops", rd_ptr - base_pop, 32'd4);
    chk("stall_exercised", {31'd0, stall_cnt > 0}, 32'd1);
    chk("stall_data_stable", stab_err, 32'd0);
    tick();

    // Starvation: 2 words for a 5-word burst, timeout 8 after the last pop.
    push(32'hC000_0001); push(32'hC000_0002);
    base_rx = rx_cnt; base_done = done_cnt;
    do_start(8'd5);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (err) got = 1'b1;
    end
    err_edge = cyc;
    chk("to_err_seen", {31'd0, got}, 32'd1);
    chk("to_err_delay", err_edge - pop_edge, 32'd8);
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    wait_done("to_done_seen", 10);
    tick();
    chk("to_done_once", done_cnt - base_done, 32'd1);
    chk("to_words_sent", {24'd0, words_sent}, 32'd2);
    chk("to_rx0", rx[base_rx],     32'hC000_0001);
    chk("to_rx1", rx[base_rx + 1], 32'hC000_0002);
    chk("to_err_held", {30'd0, err, busy}, 32'd2);

    // Short burst leaves words in the FIFO; a second burst drains them.
    for (int i = 0; i < 8; i++) push(32'hA000_0000 + i);
    base_rx = rx_cnt;
    do_start(8'd3);
    wait_done("sb_done3", 20);
    chk("sb_words_sent3", {24'd0, words_sent}, 32'd3);
    chk("sb_remaining", wr_ptr - rd_ptr, 32'd5);
    chk("sb_err_cleared", {31'd0, err}, 32'd0);
    tick();
    do_start(8'd5);
    wait_done("sb_done5", 20);
    chk("sb_rx_count", rx_cnt - base_rx, 32'd8);
    for (int i = 0; i < 8; i++) chk("sb_rx_word", rx[base_rx + i], 32'hA000_0000 + i);
    chk("sb_words_sent5", {24'd0, words_sent}, 32'd5);
    chk("sb_fifo_empty", wr_ptr - rd_ptr, 32'd0);
    tick();

    // Zero-length burst: immediate done, no pop even with data available.
    push(32'h5555_0001);
    base_pop = rd_ptr;
    do_start(8'd0);
    chk("z_done", {29'd0, done, busy, err}, 32'd4);
    tick();
    chk("z_done_drop", {31'd0, done}, 32'd0);
    chk("z_no_pop", rd_ptr - base_pop, 32'd0);

    // A start pulse while busy is ignored: only the first burst's word pops.
    push(32'h5555_0002);
    out_ready = 1'b0;
    base_rx = rx_cnt;
    do_start(8'd1);
    tick();
    do_start(8'd5);
    out_ready = 1'b1;
    wait_done("ign_done", 20);
    tick(); tick();
    chk("ign_pops", rd_ptr - base_pop, 32'd1);
    chk("ign_words_sent", {24'd0, words_sent}, 32'd1);
    chk("ign_rx", rx[base_rx], 32'h5555_0001);
    chk("ign_idle", {31'd0, busy}, 32'd0);
    do_start(8'd1);
    wait_done("ign_cleanup_done", 20);
    chk("ign_cleanup_rx", rx[base_rx + 1], 32'h5555_0002);
    tick();

    // Reset mid-burst after two pops: outputs clear at once, FIFO untouched.
    for (int i = 0; i < 6; i++) push(32'hB000_0000 + i);
    base_pop = rd_ptr;
    do_start(8'd6);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rd_ptr - base_pop == 2) got = 1'b1;
      else tick();
    end
    chk("mr_two_pops", {31'd0, got}, 32'd1);
    rst = 1'b0;
    #1;
    chk("mr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_out_data", out_data, 32'd0);
    chk("mr_ctrl", {28'd0, busy, done, err, fifo_rd_en}, 32'd0);
    chk("mr_words_sent", {24'd0, words_sent}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_idle", {31'd0, busy}, 32'd0);
    chk("mr_fifo_left", wr_ptr - rd_ptr, 32'd4);
    base_rx = rx_cnt;
    do_start(8'd4);
    wait_done("mr_resume_done", 20);
    for (int i = 0; i < 4; i++) chk("mr_resume_word", rx[base_rx + i], 32'hB000_0002 + i);
    chk("no_pop_when_empty", empty_pops, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_keymill_fifo_reader
